// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
//   N-way round-robin arbiter onto one shared WIDTH-bit bus, with a one-entry
//   registered output stage that sustains one word per cycle. With LOCK_PKT
//   set, a producer that wins mid-packet keeps the grant until its last beat.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   NUM_IN        channel i holds a word
//   in_last    NUM_IN        channel i's current word ends its packet
//   in_ready   NUM_IN        channel i's word is taken this cycle (one-hot or zero)
//   out_data   WIDTH         registered bus word
//   out_sel    SEL_W         index of the channel that supplied out_data
//   out_last   1             registered in_last for out_data
//   out_valid  1             out_data holds a word
//   out_ready  1             downstream consumes the word
module rr_bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 4,
    parameter int LOCK_PKT = 1,
    parameter int SEL_W    = $clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } arb_state_t;

    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] lock_ch, lock_ch_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;

    logic             accept;
    logic             gnt_found;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W:0]   scan_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_last;
    logic             xfer_in;

    // The stage can take a word when empty or when its word leaves this cycle.
    assign accept = !out_valid || out_ready;

    // Grant selection: a locked channel owns the bus (even while its valid
    // is low); otherwise scan from ptr upward, wrapping at NUM_IN so unused
    // indices of a non-power-of-two count are never visited.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (state == ST_LOCKED) begin
            gnt_found = in_valid[lock_ch];
            gnt_idx   = lock_ch;
        end else begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                scan_idx = {1'b0, ptr} + (SEL_W+1)'(k);
                if (scan_idx >= NUM_IN_W) begin
                    scan_idx = scan_idx - NUM_IN_W;
                end
                if (!gnt_found && in_valid[scan_idx[SEL_W-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan_idx[SEL_W-1:0];
                end
            end
        end
    end

    // Data/last mux for the granted channel, built from constant slices.
    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
                gnt_last = in_last[i];
            end
        end
    end

    // Reset gates the handshake directly: the async clear of out_valid would
    // otherwise make accept true while reset is still asserted.
    assign xfer_in = gnt_found && accept && !reset;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_ready[i] = xfer_in && (gnt_idx == SEL_W'(i));
        end
    end

    // Lock / pointer next-state.
    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        ptr_nxt     = ptr;
        if (xfer_in) begin
            if ((LOCK_PKT != 0) && !gnt_last) begin
                state_nxt   = ST_LOCKED;
                lock_ch_nxt = gnt_idx;
            end else begin
                state_nxt = ST_OPEN;
                ptr_nxt   = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_OPEN;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Output stage: a new word replaces a departing one in the same cycle,
    // so back-to-back transfers carry no bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            out_last  <= gnt_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter
//   Directed bench for rr_bus_arbiter. Three instances share one clock:
//   a: NUM_IN=4, LOCK_PKT=0 (fairness, backpressure, wrap/sparse)
//   b: NUM_IN=4, LOCK_PKT=1 (packet lock, async reset mid-packet)
//   c: NUM_IN=3, LOCK_PKT=0 (non-power-of-two wrap)
module tb_rr_bus_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // instance a
    logic         a_rst;
    logic [127:0] a_data;
    logic [3:0]   a_valid, a_last, a_ready;
    logic [31:0]  a_odata;
    logic [1:0]   a_sel;
    logic         a_olast, a_ovalid, a_ordy;

    // instance b
    logic         b_rst;
    logic [127:0] b_data;
    logic [3:0]   b_valid, b_last, b_ready;
    logic [31:0]  b_odata;
    logic [1:0]   b_sel;
    logic         b_olast, b_ovalid, b_ordy;

    // instance c
    logic         c_rst;
    logic [95:0]  c_data;
    logic [2:0]   c_valid, c_last, c_ready;
    logic [31:0]  c_odata;
    logic [1:0]   c_sel;
    logic         c_olast, c_ovalid, c_ordy;

    rr_bus_arbiter #(.WIDTH(32), .NUM_IN(4), .LOCK_PKT(0)) dut_a (
        .clock(clock), .reset(a_rst), .in_data(a_data), .in_valid(a_valid),
        .in_last(a_last), .in_ready(a_ready), .out_data(a_odata), .out_sel(a_sel),
        .out_last(a_olast), .out_valid(a_ovalid), .out_ready(a_ordy)
    );

    rr_bus_arbiter #(.WIDTH(32), .NUM_IN(4), .LOCK_PKT(1)) dut_b (
        .clock(clock), .reset(b_rst), .in_data(b_data), .in_valid(b_valid),
        .in_last(b_last), .in_ready(b_ready), .out_data(b_odata), .out_sel(b_sel),
        .out_last(b_olast), .out_valid(b_ovalid), .out_ready(b_ordy)
    );

    rr_bus_arbiter #(.WIDTH(32), .NUM_IN(3), .LOCK_PKT(0)) dut_c (
        .clock(clock), .reset(c_rst), .in_data(c_data), .in_valid(c_valid),
        .in_last(c_last), .in_ready(c_ready), .out_data(c_odata), .out_sel(c_sel),
        .out_last(c_olast), .out_valid(c_ovalid), .out_ready(c_ordy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
        a_valid = 4'b1111; a_last = 4'b1111;
        b_valid = '0;      b_last = 4'b1111;
        c_valid = 3'b111;  c_last = 3'b111;
        for (int i = 0; i < 4; i++) begin
            a_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            b_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
        end
        for (int i = 0; i < 3; i++) begin
            c_data[i*32 +: 32] = 32'hC000_0000 + 32'(i);
        end
        tick();

        // reset state, in_ready held low even with requests pending
        check("rst_a_valid", 32'(a_ovalid), 32'd0);
        check("rst_a_data",  a_odata,       32'd0);
        check("rst_a_sel",   32'(a_sel),    32'd0);
        check("rst_a_last",  32'(a_olast),  32'd0);
        check("rst_a_ready", 32'(a_ready),  32'd0);

        // ---- 1: fairness on a ----
        a_rst = 1'b0;
        #1;
        check("fair_first_ready", 32'(a_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("fair_valid", 32'(a_ovalid), 32'd1);
            check("fair_sel",   32'(a_sel),    32'(k % 4));
            check("fair_data",  a_odata,       32'hA000_0000 + 32'(k % 4));
        end

        // ---- 2: backpressure on a (ptr=1 now) ----
        a_data[32 +: 32] = 32'hDEAD_BEEF;
        tick();
        check("bp_load_sel",  32'(a_sel), 32'd1);
        check("bp_load_data", a_odata,    32'hDEAD_BEEF);
        a_ordy = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_data",  a_odata,       32'hDEAD_BEEF);
            check("bp_hold_valid", 32'(a_ovalid), 32'd1);
            check("bp_hold_ready", 32'(a_ready),  32'd0);
            tick();
        end
        check("bp_after_data", a_odata, 32'hDEAD_BEEF);
        a_ordy = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_ready), 32'b0100);
        tick();
        check("bp_next_sel",  32'(a_sel), 32'd2);
        check("bp_next_data", a_odata,    32'hA000_0002);

        // ---- 3: wrap / sparse on a (ptr=3) ----
        a_valid = 4'b0010;
        #1;
        check("wrap_ready", 32'(a_ready), 32'b0010);
        tick();
        check("wrap_sel",   32'(a_sel),    32'd1);
        check("wrap_valid", 32'(a_ovalid), 32'd1);
        a_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(a_ovalid), 32'd0);
        check("drain_sel",   32'(a_sel),    32'd1);
        check("drain_data",  a_odata,       32'hDEAD_BEEF);
        a_valid = 4'b1111;
        #1;
        check("wrap_ptr2_ready", 32'(a_ready), 32'b0100);

        // ---- 4: packet lock on b ----
        b_rst = 1'b0;
        b_valid = 4'b0001;
        #1;
        check("lk_pre_ready", 32'(b_ready), 32'b0001);
        tick();
        check("lk_pre_sel", 32'(b_sel), 32'd0);
        b_valid = 4'b1101;
        b_last  = 4'b1011;
        #1;
        check("lk_b1_ready", 32'(b_ready), 32'b0100);
        tick();
        check("lk_b1_sel",  32'(b_sel),   32'd2);
        check("lk_b1_last", 32'(b_olast), 32'd0);
        check("lk_b1_data", b_odata,      32'hB000_0002);
        tick();
        check("lk_b2_sel", 32'(b_sel), 32'd2);
        b_valid = 4'b1001;
        #1;
        check("lk_gap_ready", 32'(b_ready), 32'b0000);
        tick();
        check("lk_gap_valid", 32'(b_ovalid), 32'd0);
        b_valid = 4'b1101;
        b_last  = 4'b1111;
        #1;
        check("lk_b3_ready", 32'(b_ready), 32'b0100);
        tick();
        check("lk_b3_sel",  32'(b_sel),   32'd2);
        check("lk_b3_last", 32'(b_olast), 32'd1);
        tick();
        check("lk_ch3_sel", 32'(b_sel), 32'd3);
        tick();
        check("lk_ch0_sel", 32'(b_sel), 32'd0);

        // ---- 5: async reset mid-packet on b (ptr=1) ----
        b_last = 4'b1011;
        #1;
        check("ar_b1_ready", 32'(b_ready), 32'b0100);
        tick();
        check("ar_b1_sel", 32'(b_sel), 32'd2);
        #1;
        b_rst = 1'b1;
        #1;
        check("ar_valid_now", 32'(b_ovalid), 32'd0);
        check("ar_ready_now", 32'(b_ready),  32'd0);
        check("ar_sel_now",   32'(b_sel),    32'd0);
        #1;
        b_rst = 1'b0;
        #1;
        check("ar_restart_ready", 32'(b_ready), 32'b0001);
        tick();
        check("ar_restart_sel",  32'(b_sel), 32'd0);
        check("ar_restart_data", b_odata,    32'hB000_0000);

        // ---- 6: NUM_IN=3 wrap on c ----
        c_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("n3_valid", 32'(c_ovalid), 32'd1);
            check("n3_sel",   32'(c_sel),    32'(k % 3));
            check("n3_data",  c_odata,       32'hC000_0000 + 32'(k % 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
